// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, encodings, fetch FSM states and the
// IF/ID payload carried between fetch and decode.
package pipe_pkg;

   localparam int PC_W    = 16;
   localparam int INSTR_W = 16;

   localparam logic [INSTR_W-1:0] NOP_INSTR    = 16'h0800;
   localparam logic [PC_W-1:0]    PC_INC       = 16'd2;
   localparam logic [PC_W-1:0]    RESET_PC_DEF = 16'h0000;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      WAIT   = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [PC_W-1:0]    pc_plus2;
      logic               valid;
   } if_id_t;

   // Empty slot as seen by decode: NOP encoding, zero PC, not valid.
   function automatic if_id_t bubble_payload();
      if_id_t p;
      p.instr    = NOP_INSTR;
      p.pc_plus2 = 16'h0000;
      p.valid    = 1'b0;
      return p;
   endfunction

   // Real instruction paired with the PC of the next sequential instruction.
   function automatic if_id_t make_payload(input logic [INSTR_W-1:0] instr,
                                           input logic [PC_W-1:0]    pc_plus2);
      if_id_t p;
      p.instr    = instr;
      p.pc_plus2 = pc_plus2;
      p.valid    = 1'b1;
      return p;
   endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Bubble wins over load; otherwise the contents hold.
module if_id_reg
   import pipe_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   load,
   input  logic   bubble,
   input  if_id_t din,
   output if_id_t dout
);

   if_id_t pay_d;
   if_id_t pay_q;

   // Select bubble, new payload or hold.
   always_comb begin
      pay_d = pay_q;
      if (bubble) begin
         pay_d = bubble_payload();
      end else if (load) begin
         pay_d = din;
      end else begin
         pay_d = pay_q;
      end
   end

   // Payload storage; reset leaves a bubble in decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pay_q <= bubble_payload();
      end else begin
         pay_q <= pay_d;
      end
   end

   assign dout = pay_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: owns the PC, runs the imem request/done handshake,
// parks a returning instruction in a one-entry skid while decode is stalled,
// and feeds the IF/ID register.
module fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               if_stall,
   input  logic               FD_NOP,
   input  logic               redirect_en,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic               halt,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_done,
   output logic [INSTR_W-1:0] FD_instr,
   output logic [PC_W-1:0]    FD_pc_plus2,
   output logic               FD_valid,
   output logic               halted
);

   fetch_state_t    state_q, state_d, base_state_s;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [PC_W-1:0] addr_q, addr_d;
   if_id_t          skid_q, skid_d;
   logic            halt_pend_q, halt_pend_d;

   logic            req_s;
   logic            done_s;
   logic            halt_req_s;
   logic [PC_W-1:0] pc_inc_s;
   logic            fd_load_s;
   logic            fd_bubble_s;
   if_id_t          fd_din_s;
   if_id_t          fd_s;

   // Request depends only on state, skid and reset; the address of an
   // outstanding request is frozen in addr_q so a redirect cannot move it.
   always_comb begin
      req_s = 1'b0;
      case (state_q)
         FETCH:   req_s = !skid_q.valid;
         WAIT:    req_s = 1'b1;
         DRAIN:   req_s = 1'b1;
         HALTED:  req_s = 1'b0;
         default: req_s = 1'b0;
      endcase
      req_s = req_s & rst;
   end

   assign imem_req  = req_s;
   assign imem_addr = (state_q == FETCH) ? pc_q : addr_q;
   assign done_s    = imem_done & req_s;
   assign pc_inc_s  = pc_q + PC_INC;
   assign halt_req_s = halt | halt_pend_q;

   // Next state, PC, skid and IF/ID control, in priority order
   // redirect > flush > halt > stall > normal.
   always_comb begin
      pc_d         = pc_q;
      addr_d       = addr_q;
      skid_d       = skid_q;
      halt_pend_d  = halt_pend_q;
      fd_load_s    = 1'b0;
      fd_bubble_s  = 1'b0;
      fd_din_s     = bubble_payload();
      base_state_s = state_q;

      // Plain handshake progression.
      case (state_q)
         FETCH: begin
            addr_d = pc_q;
            if (req_s && !done_s) begin
               base_state_s = WAIT;
            end else begin
               base_state_s = FETCH;
            end
         end
         WAIT: begin
            if (done_s) base_state_s = FETCH;
            else        base_state_s = WAIT;
         end
         DRAIN: begin
            if (done_s) base_state_s = FETCH;
            else        base_state_s = DRAIN;
         end
         HALTED:  base_state_s = HALTED;
         default: base_state_s = FETCH;
      endcase

      // A squashed or halting path must still see its request complete.
      if (state_q == HALTED) begin
         state_d = HALTED;
      end else if (halt_req_s) begin
         if (req_s && !done_s) begin
            state_d     = DRAIN;
            halt_pend_d = 1'b1;
         end else begin
            state_d     = HALTED;
            halt_pend_d = 1'b0;
         end
      end else if (redirect_en && req_s && !done_s) begin
         state_d = DRAIN;
      end else begin
         state_d = base_state_s;
      end

      // Datapath: PC, skid and IF/ID.
      if (redirect_en) begin
         pc_d        = redirect_pc;
         fd_bubble_s = 1'b1;
         skid_d      = bubble_payload();
      end else if (FD_NOP) begin
         fd_bubble_s = 1'b1;
         skid_d      = bubble_payload();
      end else if (halt_req_s) begin
         fd_bubble_s = 1'b1;
         skid_d      = bubble_payload();
      end else if ((state_q == DRAIN) || (state_q == HALTED)) begin
         fd_bubble_s = !if_stall;
      end else if (if_stall) begin
         if (done_s) begin
            skid_d = make_payload(imem_rdata, pc_inc_s);
            pc_d   = pc_inc_s;
         end else begin
            pc_d   = pc_q;
         end
      end else if (skid_q.valid) begin
         fd_load_s = 1'b1;
         fd_din_s  = skid_q;
         skid_d    = bubble_payload();
      end else if (done_s) begin
         fd_load_s = 1'b1;
         fd_din_s  = make_payload(imem_rdata, pc_inc_s);
         pc_d      = pc_inc_s;
      end else begin
         fd_bubble_s = 1'b1;
      end
   end

   // Fetch control state; reset drops any outstanding request.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         skid_q      <= bubble_payload();
         halt_pend_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         skid_q      <= skid_d;
         halt_pend_q <= halt_pend_d;
      end
   end

   if_id_reg u_if_id (
      .clk    (clk),
      .rst    (rst),
      .load   (fd_load_s),
      .bubble (fd_bubble_s),
      .din    (fd_din_s),
      .dout   (fd_s)
   );

   assign FD_instr    = fd_s.instr;
   assign FD_pc_plus2 = fd_s.pc_plus2;
   assign FD_valid    = fd_s.valid;
   assign halted      = (state_q == HALTED);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a latency-programmable memory responder
// plus a cycle-by-cycle script with hand-computed expectations.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        if_stall;
   logic        FD_NOP;
   logic        redirect_en;
   logic [15:0] redirect_pc;
   logic        halt;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic [15:0] imem_rdata;
   logic        imem_done;
   logic [15:0] FD_instr;
   logic [15:0] FD_pc_plus2;
   logic        FD_valid;
   logic        halted;

   int checks;
   int errors;
   int lat;
   int cnt;

   fetch_stage dut (
      .clk         (clk),
      .rst         (rst),
      .if_stall    (if_stall),
      .FD_NOP      (FD_NOP),
      .redirect_en (redirect_en),
      .redirect_pc (redirect_pc),
      .halt        (halt),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .imem_done   (imem_done),
      .FD_instr    (FD_instr),
      .FD_pc_plus2 (FD_pc_plus2),
      .FD_valid    (FD_valid),
      .halted      (halted)
   );

   // 100 MHz-style free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory word at address a is 16'hC000 | a.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return 16'hC000 | a;
   endfunction

   // Memory responder: done pulses in the lat-th cycle of each request.
   initial begin
      imem_done  = 1'b0;
      imem_rdata = 16'h0000;
      cnt        = 0;
      forever begin
         @(negedge clk);
         if (!rst || !imem_req) begin
            cnt       = 0;
            imem_done = 1'b0;
         end else begin
            cnt = cnt + 1;
            if (cnt >= lat) begin
               imem_done  = 1'b1;
               imem_rdata = mem_word(imem_addr);
               cnt        = 0;
            end else begin
               imem_done  = 1'b0;
            end
         end
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         errors = errors + 1;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Safety net against a stuck simulation.
   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      lat         = 1;
      rst         = 1'b0;
      if_stall    = 1'b0;
      FD_NOP      = 1'b0;
      redirect_en = 1'b0;
      redirect_pc = 16'h0000;
      halt        = 1'b0;

      // Reset state
      step();
      step();
      check_eq("rst_valid",  {31'd0, FD_valid}, 32'd0);
      check_eq("rst_instr",  {16'd0, FD_instr}, 32'h0000_0800);
      check_eq("rst_pcp2",   {16'd0, FD_pc_plus2}, 32'd0);
      check_eq("rst_req",    {31'd0, imem_req}, 32'd0);
      check_eq("rst_halted", {31'd0, halted}, 32'd0);

      // 1: single-cycle memory streaming
      rst = 1'b1;
      #1;
      check_eq("t1_req0",  {31'd0, imem_req}, 32'd1);
      check_eq("t1_addr0", {16'd0, imem_addr}, 32'h0000);
      step();
      check_eq("t1_i0",    {16'd0, FD_instr}, 32'h0000_C000);
      check_eq("t1_p0",    {16'd0, FD_pc_plus2}, 32'h0002);
      check_eq("t1_v0",    {31'd0, FD_valid}, 32'd1);
      check_eq("t1_a2",    {16'd0, imem_addr}, 32'h0002);
      step();
      check_eq("t1_i2",    {16'd0, FD_instr}, 32'h0000_C002);
      check_eq("t1_p2",    {16'd0, FD_pc_plus2}, 32'h0004);
      check_eq("t1_a4",    {16'd0, imem_addr}, 32'h0004);
      step();
      check_eq("t1_i4",    {16'd0, FD_instr}, 32'h0000_C004);
      check_eq("t1_p4",    {16'd0, FD_pc_plus2}, 32'h0006);
      check_eq("t1_a6",    {16'd0, imem_addr}, 32'h0006);
      // FD_NOP: bubble, PC stays, same address refetched
      FD_NOP = 1'b1;
      step();
      FD_NOP = 1'b0;
      check_eq("nop_valid", {31'd0, FD_valid}, 32'd0);
      check_eq("nop_instr", {16'd0, FD_instr}, 32'h0000_0800);
      check_eq("nop_addr",  {16'd0, imem_addr}, 32'h0006);
      step();
      check_eq("nop_i6",    {16'd0, FD_instr}, 32'h0000_C006);
      check_eq("nop_p6",    {16'd0, FD_pc_plus2}, 32'h0008);

      // 2: three-cycle memory
      lat = 3;
      rst = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check_eq("t2_req_c1",  {31'd0, imem_req}, 32'd1);
      check_eq("t2_addr_c1", {16'd0, imem_addr}, 32'h0000);
      step();
      check_eq("t2_req_c2",  {31'd0, imem_req}, 32'd1);
      check_eq("t2_addr_c2", {16'd0, imem_addr}, 32'h0000);
      check_eq("t2_v_c2",    {31'd0, FD_valid}, 32'd0);
      step();
      check_eq("t2_addr_c3", {16'd0, imem_addr}, 32'h0000);
      check_eq("t2_v_c3",    {31'd0, FD_valid}, 32'd0);
      step();
      check_eq("t2_v_up",    {31'd0, FD_valid}, 32'd1);
      check_eq("t2_i0",      {16'd0, FD_instr}, 32'h0000_C000);
      check_eq("t2_p0",      {16'd0, FD_pc_plus2}, 32'h0002);
      check_eq("t2_addr2",   {16'd0, imem_addr}, 32'h0002);
      step();
      check_eq("t2_gap_v",   {31'd0, FD_valid}, 32'd0);
      step();
      step();
      check_eq("t2_i2",      {16'd0, FD_instr}, 32'h0000_C002);

      // 3: stall across the return of addr 4 -> skid
      if_stall = 1'b1;
      step();
      step();
      step();
      check_eq("t3_req_skid", {31'd0, imem_req}, 32'd0);
      check_eq("t3_hold_i",   {16'd0, FD_instr}, 32'h0000_C002);
      check_eq("t3_hold_p",   {16'd0, FD_pc_plus2}, 32'h0004);
      step();
      check_eq("t3_req_skid2", {31'd0, imem_req}, 32'd0);
      check_eq("t3_hold_i2",   {16'd0, FD_instr}, 32'h0000_C002);
      if_stall = 1'b0;
      step();
      check_eq("t3_i4",   {16'd0, FD_instr}, 32'h0000_C004);
      check_eq("t3_p4",   {16'd0, FD_pc_plus2}, 32'h0006);
      check_eq("t3_req",  {31'd0, imem_req}, 32'd1);
      check_eq("t3_a6",   {16'd0, imem_addr}, 32'h0006);

      // 4: redirect while waiting on addr 8
      step();
      step();
      step();
      check_eq("t4_i6",   {16'd0, FD_instr}, 32'h0000_C006);
      step();
      check_eq("t4_a8",   {16'd0, imem_addr}, 32'h0008);
      redirect_en = 1'b1;
      redirect_pc = 16'h0040;
      step();
      redirect_en = 1'b0;
      check_eq("t4_v",       {31'd0, FD_valid}, 32'd0);
      check_eq("t4_instr",   {16'd0, FD_instr}, 32'h0000_0800);
      check_eq("t4_drain_r", {31'd0, imem_req}, 32'd1);
      check_eq("t4_drain_a", {16'd0, imem_addr}, 32'h0008);
      step();
      check_eq("t4_a40",  {16'd0, imem_addr}, 32'h0040);
      check_eq("t4_req",  {31'd0, imem_req}, 32'd1);
      check_eq("t4_v2",   {31'd0, FD_valid}, 32'd0);

      // 5: redirect under stall with a full skid
      if_stall = 1'b1;
      step();
      step();
      step();
      check_eq("t5_req_skid", {31'd0, imem_req}, 32'd0);
      redirect_en = 1'b1;
      redirect_pc = 16'h0100;
      step();
      redirect_en = 1'b0;
      if_stall    = 1'b0;
      check_eq("t5_req",  {31'd0, imem_req}, 32'd1);
      check_eq("t5_a100", {16'd0, imem_addr}, 32'h0100);
      check_eq("t5_v",    {31'd0, FD_valid}, 32'd0);
      step();
      check_eq("t5_noleak_v", {31'd0, FD_valid}, 32'd0);
      check_eq("t5_noleak_i", {16'd0, FD_instr}, 32'h0000_0800);
      step();
      step();
      check_eq("t5_i100", {16'd0, FD_instr}, 32'h0000_C100);
      check_eq("t5_p100", {16'd0, FD_pc_plus2}, 32'h0102);

      // 6a: reset in the middle of a wait
      step();
      check_eq("t6_wait_a", {16'd0, imem_addr}, 32'h0102);
      rst = 1'b0;
      #1;
      check_eq("t6_rst_req", {31'd0, imem_req}, 32'd0);
      check_eq("t6_rst_v",   {31'd0, FD_valid}, 32'd0);
      check_eq("t6_rst_i",   {16'd0, FD_instr}, 32'h0000_0800);
      step();
      rst = 1'b1;
      #1;
      check_eq("t6_post_req", {31'd0, imem_req}, 32'd1);
      check_eq("t6_post_a",   {16'd0, imem_addr}, 32'h0000);

      // 6b: halt with a request in flight
      halt = 1'b1;
      step();
      halt = 1'b0;
      check_eq("t6_h_req1",  {31'd0, imem_req}, 32'd1);
      check_eq("t6_h_addr1", {16'd0, imem_addr}, 32'h0000);
      check_eq("t6_h_hlt1",  {31'd0, halted}, 32'd0);
      check_eq("t6_h_v1",    {31'd0, FD_valid}, 32'd0);
      step();
      check_eq("t6_h_req2",  {31'd0, imem_req}, 32'd1);
      check_eq("t6_h_hlt2",  {31'd0, halted}, 32'd0);
      step();
      check_eq("t6_h_req3",  {31'd0, imem_req}, 32'd0);
      check_eq("t6_h_hlt3",  {31'd0, halted}, 32'd1);
      check_eq("t6_h_v3",    {31'd0, FD_valid}, 32'd0);
      redirect_en = 1'b1;
      redirect_pc = 16'h0200;
      step();
      redirect_en = 1'b0;
      check_eq("t6_h_req4",  {31'd0, imem_req}, 32'd0);
      check_eq("t6_h_hlt4",  {31'd0, halted}, 32'd1);
      step();
      step();
      check_eq("t6_h_req5",  {31'd0, imem_req}, 32'd0);
      check_eq("t6_h_hlt5",  {31'd0, halted}, 32'd1);

      // PC wraps from 16'hFFFE to 16'h0000
      lat = 1;
      rst = 1'b0;
      step();
      rst         = 1'b1;
      redirect_en = 1'b1;
      redirect_pc = 16'hFFFE;
      step();
      redirect_en = 1'b0;
      check_eq("wr_hlt",   {31'd0, halted}, 32'd0);
      check_eq("wr_afffe", {16'd0, imem_addr}, 32'h0000_FFFE);
      check_eq("wr_v0",    {31'd0, FD_valid}, 32'd0);
      step();
      check_eq("wr_i",     {16'd0, FD_instr}, 32'h0000_FFFE);
      check_eq("wr_p",     {16'd0, FD_pc_plus2}, 32'h0000);
      check_eq("wr_v",     {31'd0, FD_valid}, 32'd1);
      check_eq("wr_a0",    {16'd0, imem_addr}, 32'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
